// File: rtl/seq_tail_light_if.sv
// Signal bundle between the switch debouncers and seq_tail_light.
// The brake signal exists only when TAIL_BRAKE_EN is defined.
`timescale 1ns/1ps
interface seq_tail_light_if #(
  parameter int unsigned LAMPS = 3
);
  logic                 left;
  logic                 right;
  logic                 haz;
`ifdef TAIL_BRAKE_EN
  logic                 brake;
`endif
  logic [2*LAMPS-1:0]   light;
  logic                 busy;

`ifdef TAIL_BRAKE_EN
  modport master (output left, output right, output haz, output brake,
                  input light, input busy);
  modport slave  (input left, input right, input haz, input brake,
                  output light, output busy);
`else
  modport master (output left, output right, output haz,
                  input light, input busy);
  modport slave  (input left, input right, input haz,
                  output light, output busy);
`endif
endinterface

// File: rtl/seq_tail_light.sv
// Sequential tail-light controller: progressive turn animation, hazard flash,
// each step held STEP_DIV cycles. Define TAIL_BRAKE_EN for the brake overlay.
`timescale 1ns/1ps
module seq_tail_light #(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_tail_light_if.slave bus
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned KW = $clog2(LAMPS + 2);

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  state_t             state_q, state_d, eval_state;
  logic [KW-1:0]      k_q, k_d, eval_k;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*LAMPS-1:0] light_q, light_d;
  logic               busy_q;
  logic               hz, strobe, changed;
  logic [LAMPS-1:0]   l_side, r_side;

  always_comb begin
    hz     = bus.haz | (bus.left & bus.right);
    strobe = (cnt_q == CW'(STEP_DIV - 1));

    eval_state = IDLE;
    eval_k     = '0;
    if (hz) begin
      eval_state = HAZ_ON;
    end else if (bus.left) begin
      eval_state = LEFT;
      eval_k     = KW'(1);
    end else if (bus.right) begin
      eval_state = RIGHT;
      eval_k     = KW'(1);
    end

    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        state_d = eval_state;
        k_d     = eval_k;
      end
      LEFT, RIGHT: begin
        if (strobe) begin
          if (k_q <= KW'(LAMPS)) begin
            if (hz) begin
              state_d = HAZ_ON;
              k_d     = '0;
            end else begin
              k_d = k_q + KW'(1);
            end
          end else begin
            state_d = eval_state;
            k_d     = eval_k;
          end
        end
      end
      HAZ_ON: begin
        if (strobe) begin
          state_d = HAZ_OFF;
        end
      end
      HAZ_OFF: begin
        if (strobe) begin
          state_d = eval_state;
          k_d     = eval_k;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase

    // Re-entering the same sequence (e.g. LEFT(LAMPS+1) -> LEFT(1)) still counts as a change.
    changed = (state_d != state_q) || (k_d != k_q);
    if (state_d == IDLE || changed || strobe) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    l_side = '0;
    r_side = '0;
    for (int unsigned i = 0; i < LAMPS; i++) begin
      if (state_d == LEFT && 32'(k_d) > i && 32'(k_d) <= LAMPS) begin
        l_side[i] = 1'b1;
      end
      if (state_d == RIGHT && 32'(k_d) > i && 32'(k_d) <= LAMPS) begin
        r_side[LAMPS-1-i] = 1'b1;
      end
    end
    if (state_d == HAZ_ON) begin
      l_side = '1;
      r_side = '1;
    end

`ifdef TAIL_BRAKE_EN
    // Brake lights every side that is not currently animating.
    if (bus.brake) begin
      if (state_d == IDLE || state_d == RIGHT) begin
        l_side = '1;
      end
      if (state_d == IDLE || state_d == LEFT) begin
        r_side = '1;
      end
    end
`endif

    light_d = {l_side, r_side};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      light_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.light = light_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/seq_tail_light.md
# seq_tail_light

Parametrised sequential tail-light controller: drives LAMPS lamps per side with a progressive turn animation, hazard flashing and an optional brake overlay. Each animation step is held for a programmable number of clock cycles. It sits between the debounced switch inputs and the lamp drivers, and supersedes the fixed 3-lamp, one-step-per-clock controller.

## Interface
- LAMPS, 3, lamps per side; legal range 1..16.
- STEP_DIV, 4, clock cycles each animation step is held; must be ≥1.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high.
- left  input  1  left-turn request, level-sensitive.
- right  input  1  right-turn request, level-sensitive.
- haz  input  1  hazard request, level-sensitive.
- brake  input  1  brake pedal; the port exists only when TAIL_BRAKE_EN is defined.
- light  output  2*LAMPS  lamp drives, registered.
  - [2*LAMPS-1:LAMPS] is the left side; bit LAMPS is the left inner lamp.
  - [LAMPS-1:0] is the right side; bit LAMPS-1 is the right inner lamp.
- busy  output  1  high while the FSM is not in IDLE; registered.

## Operation
- States:
  - IDLE.
  - LEFT(k), RIGHT(k), with k=1..LAMPS+1.
  - HAZ_ON, HAZ_OFF.
- Hazard request = haz | (left & right).
- Evaluation priority is identical in IDLE and at every re-evaluation point:
  1. Hazard request → HAZ_ON.
  2. left → LEFT(1).
  3. right → RIGHT(1).
  4. Otherwise → IDLE.
- Patterns:
  - LEFT(k), k≤LAMPS: the k innermost left lamps are on.
  - RIGHT(k), k≤LAMPS: the k innermost right lamps are on.
  - LEFT(LAMPS+1), RIGHT(LAMPS+1): all lamps off.
  - HAZ_ON: all 2*LAMPS lamps on.
  - HAZ_OFF: all lamps off.
  - IDLE: all lamps off.
- Step strobe:
  - The step counter runs 0..STEP_DIV-1 in every non-IDLE state.
  - The strobe fires when the counter equals STEP_DIV-1.
  - The counter clears on every state change, and is held at 0 in IDLE.
- Transitions on a strobe:
  - LEFT(k)/RIGHT(k), k≤LAMPS:
    - If a hazard request is active → HAZ_ON (abort).
    - Otherwise → k+1.
  - LEFT(LAMPS+1), RIGHT(LAMPS+1), HAZ_OFF: re-evaluate by priority.
  - HAZ_ON → HAZ_OFF.
- Releasing left/right mid-sequence does not abort; the sequence runs to its off step.
- An opposite-side request alone is ignored until the next re-evaluation.
- Reset, including mid-sequence:
  - State returns to IDLE; counter = 0.
  - light = 0 and busy = 0 immediately (asynchronous).
  - After reset deasserts, the first evaluation occurs on the next clock edge.

## Timing
- IDLE acceptance: inputs are sampled on edge n. The new state and its light pattern are both visible after edge n, so request-to-lamp latency is 1 edge.
- light and busy are registered from next-state; they never lag the state.
- Every non-IDLE pattern is held exactly STEP_DIV cycles.
- A held turn request gives period (LAMPS+1)*STEP_DIV cycles with no idle gap.
- A held hazard request gives period 2*STEP_DIV cycles.
- Abort latency, left/right → HAZ_ON: at most STEP_DIV cycles, taken at the next strobe.
- STEP_DIV=1: the pattern advances on every edge.
- Counter width is max(1, $clog2(STEP_DIV)).

## Configuration
- TAIL_BRAKE_EN defined:
  - The brake port is present.
  - While brake=1, every lamp on a side that is not animating is forced on:
    - IDLE → all 2*LAMPS lamps on.
    - LEFT(*) → right side all on; the left animation is unchanged.
    - RIGHT(*) → left side all on; the right animation is unchanged.
    - HAZ_* → unaffected.
  - The overlay goes through the output register: 1-edge latency.
  - brake does not affect state, busy or the counter.
- TAIL_BRAKE_EN undefined: no brake port; light is purely the FSM pattern.

## Test plan
All scenarios use LAMPS=3, STEP_DIV=4.
- Reset, then idle inputs → light=6'b000000 and busy=0 indefinitely. Assert reset mid-LEFT(2) → light=0 with no clock edge.
- Pulse left for 1 cycle:
  - light = 001000, 011000, 111000, 000000, each held 4 cycles.
  - Then IDLE with busy=0.
  - Total busy time is 16 cycles.
- Hold right continuously → 000100, 000110, 000111, 000000 repeating with period 16 cycles and no idle gap.
- Hold left, then assert haz during LEFT(2) → 011000 completes its 4 cycles, then 111111 for 4 and 000000 for 4, repeating. Drop haz with left still high → re-evaluation enters LEFT(1).
- Assert left and right in the same cycle from IDLE → hazard pattern 111111/000000 with 4-cycle phases.
- With TAIL_BRAKE_EN:
  - brake=1 in IDLE → 111111 after 1 edge.
  - brake=1 with left held → 001111, 011111, 111111, 000111.
  - Rerun with STEP_DIV=1 → the pattern changes on every edge.
